// File: rtl/video_mux_sched.sv
// Frame-synchronous mode/overlay/channel scheduler for the display video mux.
// Optional auto-cycle mode is built only when VMUX_AUTO_CYCLE_EN is defined.
module video_mux_sched #(
    parameter int unsigned NUM_MODES   = 4,
    parameter int unsigned AUTO_FRAMES = 60
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       mode_btn_in,
    input  logic       frame_start_in,
    input  logic [1:0] overlay_sw_in,
    input  logic [2:0] channel_sw_in,
    input  logic       auto_en_in,
    output logic [2:0] mode_out,
    output logic       staff_en_out,
    output logic       crosshair_en_out,
    output logic [2:0] channel_sel_out,
    output logic       pending_out,
    output logic       mode_changed_out
);

    if (NUM_MODES < 2 || NUM_MODES > 8) begin : gen_bad_num_modes
        $error("NUM_MODES must be in 2..8");
    end

`ifdef VMUX_AUTO_CYCLE_EN
    typedef enum logic [1:0] {StIdle, StPending, StAuto} state_e;
    localparam int unsigned CntW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    logic [CntW-1:0] frame_cnt;
    logic            go_auto;
`else
    typedef enum logic [1:0] {StIdle, StPending} state_e;
    logic unused_auto;
    assign unused_auto = auto_en_in ^ (AUTO_FRAMES == 0);
`endif

    state_e     state;
    logic [2:0] pend_mode;
    logic       btn_q;
    logic       fs_q;
    logic       press;
    logic       frame_edge;

    assign press      = mode_btn_in & ~btn_q;
    // A held frame_start counts once, on its rising edge.
    assign frame_edge = frame_start_in & ~fs_q;
`ifdef VMUX_AUTO_CYCLE_EN
    assign go_auto    = frame_edge & auto_en_in;
`endif

    function automatic logic [2:0] next_mode(input logic [2:0] x);
        return (x == 3'(NUM_MODES - 1)) ? 3'd0 : x + 3'd1;
    endfunction

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state            <= StIdle;
            mode_out         <= 3'd0;
            pend_mode        <= 3'd0;
            staff_en_out     <= 1'b0;
            crosshair_en_out <= 1'b0;
            channel_sel_out  <= 3'd0;
            pending_out      <= 1'b0;
            mode_changed_out <= 1'b0;
            btn_q            <= 1'b0;
            fs_q             <= 1'b0;
`ifdef VMUX_AUTO_CYCLE_EN
            frame_cnt        <= '0;
`endif
        end else begin
            btn_q            <= mode_btn_in;
            fs_q             <= frame_start_in;
            mode_changed_out <= 1'b0;

            if (frame_edge) begin
                staff_en_out     <= overlay_sw_in[1];
                crosshair_en_out <= overlay_sw_in[0];
                channel_sel_out  <= channel_sw_in;
            end

            unique case (state)
                StIdle: begin
`ifdef VMUX_AUTO_CYCLE_EN
                    if (go_auto) begin
                        state     <= StAuto;
                        frame_cnt <= '0;
                    end else
`endif
                    if (press) begin
                        pend_mode   <= next_mode(mode_out);
                        state       <= StPending;
                        pending_out <= 1'b1;
                    end
                end
                StPending: begin
`ifdef VMUX_AUTO_CYCLE_EN
                    if (go_auto) begin
                        state       <= StAuto;
                        pending_out <= 1'b0;
                        frame_cnt   <= '0;
                    end else
`endif
                    begin
                        // On a coincident commit, pend_mode is the value being committed,
                        // so next(pend_mode) re-queues next(committed mode).
                        if (press) begin
                            pend_mode <= next_mode(pend_mode);
                        end
                        if (frame_edge) begin
                            mode_out         <= pend_mode;
                            mode_changed_out <= (pend_mode != mode_out);
                            if (!press) begin
                                state       <= StIdle;
                                pending_out <= 1'b0;
                            end
                        end
                    end
                end
`ifdef VMUX_AUTO_CYCLE_EN
                StAuto: begin
                    if (frame_edge) begin
                        if (!auto_en_in) begin
                            state     <= StIdle;
                            frame_cnt <= '0;
                        end else if (frame_cnt == CntW'(AUTO_FRAMES - 1)) begin
                            mode_out         <= next_mode(mode_out);
                            mode_changed_out <= 1'b1;
                            frame_cnt        <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state       <= StIdle;
                    pending_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
